// File: rtl/mdsa_top.sv
// mdsa_top: shear-sort accelerator for a 4x4 matrix of unsigned words.
//
// Sixteen words are loaded serially in row-major order. The matrix is then
// sorted in place over five single-cycle phases: row, column, row, column,
// row. The result streams out serially in ascending order.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   en            load qualifier, used only while loading
//   start         level request to begin a run, honoured only when idle
//   data_in       serial element input, row-major
//   rdy           high while idle (a start will be accepted)
//   output_enable high on each of the 16 cycles data_out carries a result
//   data_out      registered sorted output, holds its last value afterwards
module mdsa_top #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              rdy,
  output logic              output_enable,
  output logic [DATA_W-1:0] data_out
);

  typedef logic [DATA_W-1:0]      word_t;
  typedef logic [3:0][DATA_W-1:0] quad_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROW1,
    COL1,
    ROW2,
    COL2,
    ROW3,
    OUT
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0]                idx_q, idx_d;
  logic [3:0][3:0][DATA_W-1:0] m_q, m_d;
  logic                      rdy_q, rdy_d;
  logic                      oe_q, oe_d;
  word_t                     dout_q, dout_d;

  function automatic word_t min_w(word_t a, word_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic word_t max_w(word_t a, word_t b);
    return (a < b) ? b : a;
  endfunction

  // 4-input bitonic network. Stage 1 builds a bitonic sequence
  // (ascending pair, descending pair), stages 2-3 merge it ascending.
  // A descending result is the ascending one read in reverse.
  function automatic quad_t sort4(quad_t x, logic desc);
    quad_t a, b, c, r;
    a[0] = min_w(x[0], x[1]);
    a[1] = max_w(x[0], x[1]);
    a[2] = max_w(x[2], x[3]);
    a[3] = min_w(x[2], x[3]);
    b[0] = min_w(a[0], a[2]);
    b[2] = max_w(a[0], a[2]);
    b[1] = min_w(a[1], a[3]);
    b[3] = max_w(a[1], a[3]);
    c[0] = min_w(b[0], b[1]);
    c[1] = max_w(b[0], b[1]);
    c[2] = min_w(b[2], b[3]);
    c[3] = max_w(b[2], b[3]);
    if (desc) begin
      r[0] = c[3];
      r[1] = c[2];
      r[2] = c[1];
      r[3] = c[0];
    end else begin
      r = c;
    end
    return r;
  endfunction

  always_comb begin
    quad_t col_in, col_out;
    logic [1:0] out_col;

    state_d = state_q;
    idx_d   = idx_q;
    m_d     = m_q;
    dout_d  = dout_q;
    oe_d    = 1'b0;
    col_in  = '0;
    col_out = '0;
    out_col = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end

      LOAD: begin
        if (en) begin
          m_d[idx_q[3:2]][idx_q[1:0]] = data_in;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = ROW1;
          end
        end
      end

      ROW1, ROW2, ROW3: begin
        // Even rows ascending, odd rows descending, so the snake read-out
        // order is globally sorted after the final row phase.
        for (int unsigned r = 0; r < 4; r++) begin
          m_d[r] = sort4(m_q[r], (r % 2) == 1);
        end
        case (state_q)
          ROW1:    state_d = COL1;
          ROW2:    state_d = COL2;
          default: state_d = OUT;
        endcase
        idx_d = '0;
      end

      COL1, COL2: begin
        for (int unsigned c = 0; c < 4; c++) begin
          for (int unsigned r = 0; r < 4; r++) begin
            col_in[r] = m_q[r][c];
          end
          col_out = sort4(col_in, 1'b0);
          for (int unsigned r = 0; r < 4; r++) begin
            m_d[r][c] = col_out[r];
          end
        end
        state_d = (state_q == COL1) ? ROW2 : ROW3;
      end

      OUT: begin
        // Snake order: odd rows are read right to left.
        out_col = idx_q[2] ? ~idx_q[1:0] : idx_q[1:0];
        dout_d  = m_q[idx_q[3:2]][out_col];
        oe_d    = 1'b1;
        idx_d   = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    m_q <= m_d;
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rdy_q   <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
    end
  end

  assign rdy           = rdy_q;
  assign output_enable = oe_q;
  assign data_out      = dout_q;

endmodule

// File: tb/tb_mdsa_top.sv
// Testbench for mdsa_top: scenario tasks drive 16-word runs, push the
// sorted expectation into a queue and pop it against the output stream.
module tb_mdsa_top;

  localparam int unsigned DATA_W = 8;

  typedef logic [7:0] vec16_t [16];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              rdy;
  logic              output_enable;
  logic [DATA_W-1:0] data_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  mdsa_top #(.DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .start(start),
    .data_in(data_in),
    .rdy(rdy),
    .output_enable(output_enable),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens on the falling edge.
  task automatic run_sort(input vec16_t w, input bit stall, input int hold_start,
                          input bit pulse_out, input string name);
    logic [7:0] tmp [16];
    logic [7:0] e;
    logic [7:0] last;
    logic [7:0] key;
    int k;
    int n;
    int j;
    bit toggle;

    k = 0;
    while (rdy !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s rdy_wait got=%b exp=1", name, rdy);
    end

    // Expected result: insertion sort of the loaded words.
    tmp = w;
    for (int i = 1; i < 16; i++) begin
      key = tmp[i];
      j = i - 1;
      while (j >= 0 && tmp[j] > key) begin
        tmp[j+1] = tmp[j];
        j--;
      end
      tmp[j+1] = key;
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(tmp[i]);
    last = tmp[15];

    start = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL %s rdy_drop got=%b exp=0", name, rdy);
    end
    for (int i = 1; i < hold_start; i++) begin
      en = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;

    n = 0;
    toggle = 1'b0;
    while (n < 16) begin
      if (stall && !toggle) begin
        en = 1'b0;
        data_in = 8'($urandom);
      end else begin
        en = 1'b1;
        data_in = w[n];
        n++;
      end
      toggle = ~toggle;
      @(negedge clk);
    end
    en = 1'b0;
    data_in = 8'($urandom);

    k = 0;
    while (output_enable !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 6) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=6", name, k);
    end
    if (output_enable !== 1'b1) begin
      exp_q.delete();
      return;
    end

    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (output_enable !== 1'b1 || data_out !== e) begin
        failures++;
        $display("FAIL %s out[%0d] got=%h oe=%b exp=%h", name, i, data_out, output_enable, e);
      end
      start = (pulse_out && i == 8);
      @(negedge clk);
    end
    start = 1'b0;

    checks++;
    if (output_enable !== 1'b0 || rdy !== 1'b1 || data_out !== last) begin
      failures++;
      $display("FAIL %s after_out oe=%b rdy=%b dout=%h exp oe=0 rdy=1 dout=%h",
               name, output_enable, rdy, data_out, last);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (output_enable !== 1'b0 || rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s stays_idle oe=%b rdy=%b exp oe=0 rdy=1", name, output_enable, rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checks++;
    if (rdy !== 1'b1 || output_enable !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_state rdy=%b oe=%b dout=%h exp 1 0 00", rdy, output_enable, data_out);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || output_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle rdy=%b oe=%b exp 1 0", rdy, output_enable);
    end
  endtask

  task automatic test_reverse();
    vec16_t w;
    for (int i = 0; i < 16; i++) w[i] = 8'(15 - i);
    run_sort(w, 1'b0, 1, 1'b0, "reverse");
  endtask

  task automatic test_stall();
    vec16_t w;
    for (int i = 0; i < 16; i++) w[i] = 8'($urandom);
    run_sort(w, 1'b1, 1, 1'b0, "stall");
  endtask

  task automatic test_duplicates();
    vec16_t w;
    for (int i = 0; i < 16; i++) w[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    run_sort(w, 1'b0, 1, 1'b0, "dup_extremes");
  endtask

  task automatic test_reset_mid();
    vec16_t w;
    int k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = 1'b1;
      data_in = 8'(15 - i);
      @(negedge clk);
    end
    en = 1'b0;
    k = 0;
    while (output_enable !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (output_enable !== 1'b1 || data_out !== 8'(i)) begin
        failures++;
        $display("FAIL reset_mid pre[%0d] got=%h oe=%b exp=%h", i, data_out, output_enable, 8'(i));
      end
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (output_enable !== 1'b0 || rdy !== 1'b1 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid abort oe=%b rdy=%b dout=%h exp 0 1 00", output_enable, rdy, data_out);
    end
    for (int g = 0; g < 4; g++) begin
      w[4*g+0] = 8'(4*g + 3);
      w[4*g+1] = 8'(4*g + 1);
      w[4*g+2] = 8'(4*g + 2);
      w[4*g+3] = 8'(4*g + 0);
    end
    run_sort(w, 1'b0, 1, 1'b0, "after_reset");
  endtask

  task automatic test_busy_start();
    vec16_t w;
    for (int i = 0; i < 16; i++) w[i] = 8'($urandom_range(0, 40));
    run_sort(w, 1'b0, 4, 1'b1, "busy_start");
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_stall();
    test_duplicates();
    test_reset_mid();
    test_busy_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
